button_conditioner: RTL and testbench

Four-channel push-button front end for the UP2 timer. It sits between the raw `BT[3:0]` pins and the control logic. Each channel synchronises and debounces its button, then emits single-`MCLK` press and release pulses. On repeat-enabled channels it also emits auto-repeat pulses while the button is held, so that holding ADD_SEC or ADD_MIN scrolls the value. All outputs are synchronous to `MCLK` and replace the per-button debouncers and edge-clocked button wiring.

---
 rtl/button_conditioner.sv | 155 +++++++++++++++
 tb/tb_button_conditioner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: four-channel push-button front end.
// Per channel: two-flop synchroniser, debounce counter, press/release strobes,
// and an optional auto-repeat FSM on channels selected by RPT_MASK.
// Auto-repeat logic is built only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined;
// otherwise PULSE mirrors PRESS on every channel.
module button_conditioner #(
    parameter int unsigned DB_CYCLES  = 503500,
    parameter int unsigned RPT_DELAY  = 12587500,
    parameter int unsigned RPT_PERIOD = 2517500,
    parameter logic [3:0]  RPT_MASK   = 4'b1100
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic [3:0] BT,
    output logic [3:0] LEVEL,
    output logic [3:0] PRESS,
    output logic [3:0] RELEASE,
    output logic [3:0] PULSE
);

    localparam int unsigned DBW = ($clog2(DB_CYCLES) > 0) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

    logic [3:0]     meta_q, sync_q;
    logic [3:0]     level_q, level_d;
    logic [3:0]     press_q, press_d;
    logic [3:0]     release_q, release_d;
    logic [3:0]     pulse_q, pulse_d;
    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];

    // Synchronise the active-low pins into active-high pressed flags.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ~BT;
            sync_q <= meta_q;
        end
    end

    // Debounce: count consecutive cycles where sync disagrees with LEVEL.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press_d   = level_d & ~level_q;
    assign release_d = ~level_d & level_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    localparam int unsigned RPW = ($clog2(RPT_DELAY) > 0) ? $clog2(RPT_DELAY) : 1;
    localparam logic [RPW-1:0] DELAY_MAX  = RPW'(RPT_DELAY - 1);
    localparam logic [RPW-1:0] PERIOD_MAX = RPW'(RPT_PERIOD - 1);

    rpt_state_e     state_q [4];
    rpt_state_e     state_d [4];
    logic [RPW-1:0] rpt_cnt_q [4];
    logic [RPW-1:0] rpt_cnt_d [4];
    logic [3:0]     rpt_hit;

    // Repeat FSM state and counter registers.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]   <= StIdle;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    // Repeat next-state: the FSM starts on the press edge itself, and the
    // next LEVEL is used so a release on the expiry edge suppresses the pulse.
    always_comb begin
        rpt_hit = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = '0;
            if (RPT_MASK[i]) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (press_d[i]) state_d[i] = StDelay;
                    end
                    StDelay: begin
                        if (!level_d[i]) begin
                            state_d[i] = StIdle;
                        end else if (rpt_cnt_q[i] == DELAY_MAX) begin
                            rpt_hit[i] = 1'b1;
                            state_d[i] = StRepeat;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (!level_d[i]) begin
                            state_d[i] = StIdle;
                        end else if (rpt_cnt_q[i] == PERIOD_MAX) begin
                            rpt_hit[i] = 1'b1;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    assign pulse_d = press_d | rpt_hit;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{RPT_MASK, RPT_DELAY, RPT_PERIOD};
    assign pulse_d = press_d;
`endif

    // Debounced level, strobes and debounce counters.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign LEVEL   = level_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign PULSE   = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random button
// activity, checked every cycle against a behavioural reference model.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [3:0] EFF_MASK = 4'b1100;
`else
    localparam logic [3:0] EFF_MASK = 4'b0000;
`endif

    logic       MCLK = 1'b0;
    logic       RST_N;
    logic [3:0] BT;
    logic [3:0] LEVEL, PRESS, RELEASE, PULSE;

    button_conditioner #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP),
        .RPT_MASK  (4'b1100)
    ) dut (
        .MCLK   (MCLK),
        .RST_N  (RST_N),
        .BT     (BT),
        .LEVEL  (LEVEL),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .PULSE  (PULSE)
    );

    always #5 MCLK = ~MCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: pipeline delay, mismatch run length, hold age.
    logic [3:0] m_s1, m_s2, m_lvl, m_press, m_release, m_pulse;
    int         m_run [4];
    int         m_age [4];

    int pulse_offs[$];
    int exp_offs[$];
    int rel_off;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        m_press = '0; m_release = '0; m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] sync;
        sync = m_s2;
        m_s2 = m_s1;
        m_s1 = ~BT;
        m_press = '0;
        m_release = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = sync[i];
                    m_run[i] = 0;
                    if (sync[i]) m_press[i] = 1'b1;
                    else m_release[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (m_press[i]) m_age[i] = 0;
            else m_age[i]++;
            m_pulse[i] = m_press[i] || (EFF_MASK[i] && m_lvl[i] && m_age[i] >= RD &&
                                        ((m_age[i] - RD) % RP) == 0);
        end
    endtask

    // Advance one clock, update the model and compare all outputs.
    task automatic step();
        @(posedge MCLK);
        #1;
        if (!RST_N) model_reset();
        else model_step();
        chk4("level", LEVEL, m_lvl);
        chk4("press", PRESS, m_press);
        chk4("release", RELEASE, m_release);
        chk4("pulse", PULSE, m_pulse);
    endtask

    // Press channel ch, log PULSE/RELEASE offsets relative to the PRESS cycle,
    // raising the button right after offset rel_at.
    task automatic run_press(input int ch, input int rel_at, input int total);
        int  waited;
        bit  seen;
        waited = 0;
        seen = 1'b0;
        pulse_offs.delete();
        rel_off = -1;
        BT[ch] = 1'b0;
        while (!seen && waited < 20) begin
            step();
            waited++;
            if (PRESS[ch]) seen = 1'b1;
        end
        chk_int($sformatf("ch%0d_press_latency", ch), waited, DB + 2);
        for (int off = 0; off <= total; off++) begin
            if (off > 0) step();
            if (PULSE[ch]) pulse_offs.push_back(off);
            if (RELEASE[ch] && rel_off < 0) rel_off = off;
            if (off == rel_at) BT[ch] = 1'b1;
        end
    endtask

    // Expected pulse offsets for LEVEL held over offsets [0, level_end).
    task automatic check_pulses(input int ch, input int level_end);
        int n;
        exp_offs.delete();
        exp_offs.push_back(0);
        if (EFF_MASK[ch]) begin
            for (int d = RD; d < level_end; d += RP) exp_offs.push_back(d);
        end
        chk_int($sformatf("ch%0d_pulse_count", ch), pulse_offs.size(), exp_offs.size());
        n = (pulse_offs.size() < exp_offs.size()) ? pulse_offs.size() : exp_offs.size();
        for (int k = 0; k < n; k++) begin
            chk_int($sformatf("ch%0d_pulse_offset%0d", ch, k), pulse_offs[k], exp_offs[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lvl_at, npress, nrel;
        int hold [4];

        // Reset with all buttons held.
        model_reset();
        RST_N = 1'b1;
        BT = 4'h0;
        #1 RST_N = 1'b0;
        #1;
        chk4("rst_level", LEVEL, 4'h0);
        chk4("rst_press", PRESS, 4'h0);
        chk4("rst_release", RELEASE, 4'h0);
        chk4("rst_pulse", PULSE, 4'h0);
        repeat (3) step();
        RST_N = 1'b1;
        n = 0;
        while (LEVEL !== 4'hf && n < 20) begin
            step();
            n++;
        end
        chk_int("rst_level_latency", n, DB + 2);
        chk4("rst_press_all", PRESS, 4'hf);
        chk4("rst_no_release", RELEASE, 4'h0);
        BT = 4'hf;
        repeat (40) step();

        // Bounce on channel 0: low 3, high 1, then held low.
        BT[0] = 1'b0;
        lvl_at = -1;
        npress = 0;
        nrel = 0;
        for (int s = 1; s <= 25; s++) begin
            step();
            if (PRESS[0]) npress++;
            if (RELEASE[0]) nrel++;
            if (LEVEL[0] && lvl_at < 0) lvl_at = s;
            if (s == 3) BT[0] = 1'b1;
            if (s == 4) BT[0] = 1'b0;
        end
        chk_int("bounce_level_cycle", lvl_at, 10);
        chk_int("bounce_press_count", npress, 1);
        chk_int("bounce_release_count", nrel, 0);
        BT[0] = 1'b1;
        repeat (15) step();

        // Unmasked channel held long: only the press pulse.
        run_press(0, 50, 60);
        check_pulses(0, 56);
        chk_int("ch0_release_offset", rel_off, 56);
        repeat (10) step();

        // Repeat channel held: pulses at 0, 20, 28, 36, 44.
        run_press(2, 44, 60);
        check_pulses(2, 50);
        chk_int("ch2_release_offset", rel_off, 50);
        repeat (10) step();

        // Release lands on the DELAY expiry edge: no repeat pulse.
        run_press(3, 14, 30);
        check_pulses(3, 20);
        chk_int("ch3_boundary_release", rel_off, 20);
        repeat (10) step();

        // Mid-press reset during REPEAT, button still held.
        run_press(3, 1000, 30);
        check_pulses(3, 31);
        RST_N = 1'b0;
        #1;
        chk4("midrst_level", LEVEL, 4'h0);
        chk4("midrst_press", PRESS, 4'h0);
        chk4("midrst_release", RELEASE, 4'h0);
        chk4("midrst_pulse", PULSE, 4'h0);
        model_reset();
        repeat (2) step();
        RST_N = 1'b1;
        run_press(3, 1000, 30);
        check_pulses(3, 31);
        BT = 4'hf;
        repeat (20) step();

        // Random activity with a mix of glitches and long holds.
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 30);
        for (int s = 0; s < 1500; s++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    BT[i] = ~BT[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(4, 60);
                end
            end
            if (s == 750) begin
                RST_N = 1'b0;
                #1;
                chk4("rand_rst_level", LEVEL, 4'h0);
                chk4("rand_rst_pulse", PULSE, 4'h0);
                repeat (2) step();
                RST_N = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
